// File: rtl/link_pkg.sv
// Shared constants and field layout for the board link transceiver.
// Optional feature macro: LINK_PARITY_EN (appends an even-parity bit to the bus).
package link_pkg;

  localparam int DEF_DATA_W        = 4;
  localparam int DEF_N_FLAGS       = 3;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_HB_PERIOD     = 1000;
  localparam int DEF_TIMEOUT       = 4000;

`ifdef LINK_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  typedef enum logic {
    LINK_DOWN = 1'b0,
    LINK_UP   = 1'b1
  } link_state_e;

  function automatic int link_w(input int data_w, input int n_flags);
    return data_w + n_flags + 1 + PARITY_BITS;
  endfunction

  function automatic int flags_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int hb_bit(input int data_w, input int n_flags);
    return data_w + n_flags;
  endfunction

  function automatic int parity_bit(input int data_w, input int n_flags);
    return data_w + n_flags + 1;
  endfunction

endpackage

// File: rtl/board_link_xcvr_if.sv
// Game-logic and pin-side signals of the board link transceiver.
// master: the transceiver itself; slave: the surrounding game logic / pins.
interface board_link_xcvr_if
  import link_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int N_FLAGS = DEF_N_FLAGS
);

  localparam int LINK_W = link_w(DATA_W, N_FLAGS);

  logic [DATA_W-1:0]  tx_data;
  logic [N_FLAGS-1:0] tx_flags;
  logic [LINK_W-1:0]  link_out;
  logic [LINK_W-1:0]  link_in;
  logic [DATA_W-1:0]  rx_data;
  logic [N_FLAGS-1:0] rx_flags;
  logic [N_FLAGS-1:0] rx_flag_rise;
  logic               rx_update;
  logic               link_up;
  logic               parity_err;

  modport master (
    input  tx_data, tx_flags, link_in,
    output link_out, rx_data, rx_flags, rx_flag_rise, rx_update, link_up, parity_err
  );

  modport slave (
    output tx_data, tx_flags, link_in,
    input  link_out, rx_data, rx_flags, rx_flag_rise, rx_update, link_up, parity_err
  );

endinterface

// File: rtl/link_sync_filter.sv
// Two-flop synchroniser on every incoming pin plus a stability counter.
// Bits set in IGNORE_MASK are synchronised but never restart the counter.
module link_sync_filter #(
  parameter int               WIDTH         = 8,
  parameter int               STABLE_CYCLES = 4,
  parameter logic [WIDTH-1:0] IGNORE_MASK   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] stable_word,
  output logic             stable
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;

  // Synchroniser chain, previous-sample copy and stability counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      stab_cnt_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  // Restart the count on any filtered change, otherwise count up and saturate.
  always_comb begin
    sync1_d    = async_in;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    stab_cnt_d = stab_cnt_q;
    if ((sync2_q & ~IGNORE_MASK) != (prev_q & ~IGNORE_MASK)) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != CNT_MAX) begin
      stab_cnt_d = stab_cnt_q + CNT_W'(1);
    end
  end

  assign stable_word = sync2_q;
  assign stable      = (stab_cnt_d == CNT_MAX);

endmodule

// File: rtl/board_link_xcvr.sv
// Point-to-point board link transceiver: registered TX bus with heartbeat,
// filtered atomic RX commit with flag rise pulses, and a heartbeat watchdog.
// Optional feature macro: LINK_PARITY_EN (even parity over data, flags and hb).
module board_link_xcvr
  import link_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int N_FLAGS       = DEF_N_FLAGS,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HB_PERIOD     = DEF_HB_PERIOD,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               rst,
  board_link_xcvr_if.master bus
);

  localparam int LINK_W    = link_w(DATA_W, N_FLAGS);
  localparam int FLAGS_LSB = flags_lsb(DATA_W);
  localparam int HB_BIT    = hb_bit(DATA_W, N_FLAGS);
  localparam int HB_CNT_W  = $clog2(HB_PERIOD);
  localparam int TO_CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [HB_CNT_W-1:0] HB_LAST = HB_CNT_W'(HB_PERIOD - 1);
  localparam logic [TO_CNT_W-1:0] TO_MAX  = TO_CNT_W'(TIMEOUT);
  localparam logic [LINK_W-1:0]   HB_MASK = LINK_W'(1) << HB_BIT;

  logic [HB_CNT_W-1:0] hb_cnt_q, hb_cnt_d;
  logic                hb_q, hb_d;
  logic [LINK_W-1:0]   link_out_q, link_out_d;
  logic                hb_prev_q, hb_prev_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  link_state_e         state_q, state_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic [N_FLAGS-1:0]  rx_flags_q, rx_flags_d;
  logic [N_FLAGS-1:0]  rx_flag_rise_q, rx_flag_rise_d;
  logic                rx_update_q, rx_update_d;
  logic                parity_err_q, parity_err_d;
  logic                perr_seen_q, perr_seen_d;

  logic [LINK_W-1:0]   stable_word;
  logic                word_stable;
  logic [DATA_W-1:0]   new_data;
  logic [N_FLAGS-1:0]  new_flags;
  logic                hb_toggle;
  logic                link_drop;
  logic                parity_bad;

  link_sync_filter #(
    .WIDTH         (LINK_W),
    .STABLE_CYCLES (STABLE_CYCLES),
    .IGNORE_MASK   (HB_MASK)
  ) u_sync_filter (
    .clk         (clk),
    .rst         (rst),
    .async_in    (bus.link_in),
    .stable_word (stable_word),
    .stable      (word_stable)
  );

  assign new_data  = stable_word[DATA_W-1:0];
  assign new_flags = stable_word[HB_BIT-1:FLAGS_LSB];
  assign hb_toggle = (stable_word[HB_BIT] != hb_prev_q);
  assign link_drop = (state_q == LINK_UP) && (state_d == LINK_DOWN);

`ifdef LINK_PARITY_EN
  assign parity_bad = ^stable_word;
`else
  assign parity_bad = 1'b0;
`endif

  // All state of the transceiver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_cnt_q       <= '0;
      hb_q           <= 1'b0;
      link_out_q     <= '0;
      hb_prev_q      <= 1'b0;
      to_cnt_q       <= '0;
      state_q        <= LINK_DOWN;
      rx_data_q      <= '0;
      rx_flags_q     <= '0;
      rx_flag_rise_q <= '0;
      rx_update_q    <= 1'b0;
      parity_err_q   <= 1'b0;
      perr_seen_q    <= 1'b0;
    end else begin
      hb_cnt_q       <= hb_cnt_d;
      hb_q           <= hb_d;
      link_out_q     <= link_out_d;
      hb_prev_q      <= hb_prev_d;
      to_cnt_q       <= to_cnt_d;
      state_q        <= state_d;
      rx_data_q      <= rx_data_d;
      rx_flags_q     <= rx_flags_d;
      rx_flag_rise_q <= rx_flag_rise_d;
      rx_update_q    <= rx_update_d;
      parity_err_q   <= parity_err_d;
      perr_seen_q    <= perr_seen_d;
    end
  end

  // TX: heartbeat divider and the packed outgoing word.
  always_comb begin
    hb_cnt_d = hb_cnt_q + HB_CNT_W'(1);
    hb_d     = hb_q;
    if (hb_cnt_q == HB_LAST) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end
`ifdef LINK_PARITY_EN
    link_out_d = {^{hb_q, bus.tx_flags, bus.tx_data}, hb_q, bus.tx_flags, bus.tx_data};
`else
    link_out_d = {hb_q, bus.tx_flags, bus.tx_data};
`endif
  end

  // Watchdog: a peer heartbeat toggle wins over a timeout in the same cycle.
  always_comb begin
    hb_prev_d = stable_word[HB_BIT];
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    if (hb_toggle) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TO_CNT_W'(1);
    end
    if (hb_toggle) begin
      state_d = LINK_UP;
    end else if (to_cnt_d == TO_MAX) begin
      state_d = LINK_DOWN;
    end
  end

  // Commit: clear flags on link loss, otherwise accept a new stable word while up.
  always_comb begin
    rx_data_d      = rx_data_q;
    rx_flags_d     = rx_flags_q;
    rx_flag_rise_d = '0;
    rx_update_d    = 1'b0;
    parity_err_d   = 1'b0;
    perr_seen_d    = perr_seen_q & word_stable;
    if (link_drop) begin
      rx_flags_d = '0;
    end else if (word_stable && (state_q == LINK_UP)) begin
      if (parity_bad) begin
        parity_err_d = ~perr_seen_q;
        perr_seen_d  = 1'b1;
      end else if ((new_data != rx_data_q) || (new_flags != rx_flags_q)) begin
        rx_data_d      = new_data;
        rx_flags_d     = new_flags;
        rx_flag_rise_d = new_flags & ~rx_flags_q;
        rx_update_d    = 1'b1;
      end
    end
  end

  assign bus.link_out     = link_out_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_flags     = rx_flags_q;
  assign bus.rx_flag_rise = rx_flag_rise_q;
  assign bus.rx_update    = rx_update_q;
  assign bus.link_up      = (state_q == LINK_UP);
  assign bus.parity_err   = parity_err_q;

endmodule

// File: tb/tb_board_link_xcvr.sv
// Self-checking bench for board_link_xcvr in loopback with default parameters.
// Optional feature macro: LINK_PARITY_EN (enables the parity corner case).
module tb_board_link_xcvr;
  import link_pkg::*;

  localparam int DATA_W    = 4;
  localparam int N_FLAGS   = 3;
  localparam int HB_PERIOD = 1000;
  localparam int TIMEOUT   = 4000;
  localparam int LINK_W    = link_w(DATA_W, N_FLAGS);
  localparam int HB        = hb_bit(DATA_W, N_FLAGS);

  typedef struct {
    logic [3:0] data;
    logic [2:0] flags;
    logic       exp_upd;
    logic [3:0] exp_data;
    logic [2:0] exp_flags;
    logic [2:0] exp_rise;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;
  int   last_hb_cyc;
  logic prev_in_hb;
  logic loop_en;
  logic [LINK_W-1:0] inj_mask;
  int   upd_cnt;
  int   perr_cnt;
  int   rise_pulses;
  logic [2:0] rise_acc;
  vec_t vecs [8];

  board_link_xcvr_if #(.DATA_W(DATA_W), .N_FLAGS(N_FLAGS)) bus ();

  board_link_xcvr dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] data, input logic [2:0] flags);
    bus.tx_data  = data;
    bus.tx_flags = flags;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (loop_en) bus.link_in = bus.link_out ^ inj_mask;
    if (bus.link_in[HB] !== prev_in_hb) last_hb_cyc = cyc;
    prev_in_hb  = bus.link_in[HB];
    upd_cnt    += int'(bus.rx_update);
    perr_cnt   += int'(bus.parity_err);
    rise_acc   |= bus.rx_flag_rise;
    if (|bus.rx_flag_rise) rise_pulses++;
  endtask

  task automatic wait_link_up(input string name);
    int n;
    n = 0;
    while (bus.link_up !== 1'b1 && n < 2 * HB_PERIOD) begin
      step();
      n++;
    end
    checkOutput(name, bus.link_up, 1'b1);
  endtask

  task automatic wait_hb_edge(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (last_hb_cyc != cyc && n < 2 * HB_PERIOD);
    checkOutput(name, (last_hb_cyc == cyc), 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_link_out"}, bus.link_out, 0);
    checkOutput({tag, "_rx_data"}, bus.rx_data, 0);
    checkOutput({tag, "_rx_flags"}, bus.rx_flags, 0);
    checkOutput({tag, "_rise"}, bus.rx_flag_rise, 0);
    checkOutput({tag, "_rx_update"}, bus.rx_update, 0);
    checkOutput({tag, "_link_up"}, bus.link_up, 0);
    checkOutput({tag, "_parity_err"}, bus.parity_err, 0);
  endtask

  initial begin
    int snap_upd;
    int snap_perr;
    int n;

    checks      = 0;
    failures    = 0;
    cyc         = 0;
    last_hb_cyc = 0;
    prev_in_hb  = 1'b0;
    loop_en     = 1'b0;
    inj_mask    = '0;
    upd_cnt     = 0;
    perr_cnt    = 0;
    rise_pulses = 0;
    rise_acc    = '0;
    bus.link_in = '0;
    applyStimulus(4'h0, 3'b000);

    vecs[0] = '{data: 4'hA, flags: 3'b101, exp_upd: 1'b1, exp_data: 4'hA, exp_flags: 3'b101, exp_rise: 3'b101};
    vecs[1] = '{data: 4'hA, flags: 3'b101, exp_upd: 1'b0, exp_data: 4'hA, exp_flags: 3'b101, exp_rise: 3'b000};
    vecs[2] = '{data: 4'h5, flags: 3'b111, exp_upd: 1'b1, exp_data: 4'h5, exp_flags: 3'b111, exp_rise: 3'b010};
    vecs[3] = '{data: 4'h5, flags: 3'b000, exp_upd: 1'b1, exp_data: 4'h5, exp_flags: 3'b000, exp_rise: 3'b000};
    vecs[4] = '{data: 4'hF, flags: 3'b110, exp_upd: 1'b1, exp_data: 4'hF, exp_flags: 3'b110, exp_rise: 3'b110};
    vecs[5] = '{data: 4'h0, flags: 3'b011, exp_upd: 1'b1, exp_data: 4'h0, exp_flags: 3'b011, exp_rise: 3'b001};
    vecs[6] = '{data: 4'h0, flags: 3'b011, exp_upd: 1'b0, exp_data: 4'h0, exp_flags: 3'b011, exp_rise: 3'b000};
    vecs[7] = '{data: 4'hC, flags: 3'b011, exp_upd: 1'b1, exp_data: 4'hC, exp_flags: 3'b011, exp_rise: 3'b000};

    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    rst     = 1'b0;
    loop_en = 1'b1;
    wait_link_up("link_up_after_reset");
    repeat (10) step();
    checkOutput("idle_rx_data", bus.rx_data, 4'h0);

    $display("[TB] table-driven loopback vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].data, vecs[i].flags);
      step();
      checkOutput("tx_word", bus.link_out[6:0], {vecs[i].flags, vecs[i].data});
      repeat (6) step();
      checkOutput("rx_update_early", bus.rx_update, 1'b0);
      step();
      checkOutput("rx_update", bus.rx_update, vecs[i].exp_upd);
      checkOutput("rx_data", bus.rx_data, vecs[i].exp_data);
      checkOutput("rx_flags", bus.rx_flags, vecs[i].exp_flags);
      checkOutput("rx_flag_rise", bus.rx_flag_rise, vecs[i].exp_rise);
      repeat (4) step();
      checkOutput("rx_update_after", bus.rx_update, 1'b0);
    end

    $display("[TB] 3-cycle glitch on data bit 0");
    snap_upd    = upd_cnt;
    inj_mask    = LINK_W'(1);
    bus.link_in = bus.link_out ^ inj_mask;
    step();
    step();
    inj_mask = '0;
    step();
    repeat (12) step();
    checkOutput("glitch_updates", upd_cnt - snap_upd, 0);
    checkOutput("glitch_rx_data", bus.rx_data, 4'hC);

    $display("[TB] flag sequence 001 -> 011 -> 010");
    applyStimulus(4'hC, 3'b001);
    repeat (10) step();
    checkOutput("seq_flags_001", bus.rx_flags, 3'b001);
    rise_acc    = '0;
    rise_pulses = 0;
    applyStimulus(4'hC, 3'b011);
    repeat (10) step();
    checkOutput("seq_flags_011", bus.rx_flags, 3'b011);
    checkOutput("seq_rise_bits", rise_acc, 3'b010);
    checkOutput("seq_rise_pulses", rise_pulses, 1);
    applyStimulus(4'hC, 3'b010);
    repeat (10) step();
    checkOutput("seq_flags_010", bus.rx_flags, 3'b010);
    checkOutput("seq_rise_none", rise_pulses, 1);

`ifdef LINK_PARITY_EN
    $display("[TB] flipped parity bit");
    wait_hb_edge("parity_hb_sync");
    snap_upd  = upd_cnt;
    snap_perr = perr_cnt;
    inj_mask  = LINK_W'(1) << parity_bit(DATA_W, N_FLAGS);
    applyStimulus(4'h3, 3'b010);
    repeat (15) step();
    checkOutput("parity_err_pulses", perr_cnt - snap_perr, 1);
    checkOutput("parity_no_update", upd_cnt - snap_upd, 0);
    checkOutput("parity_rx_data", bus.rx_data, 4'hC);
    inj_mask = '0;
    repeat (10) step();
    checkOutput("parity_recover_data", bus.rx_data, 4'h3);
`else
    checkOutput("parity_err_tied", perr_cnt, 0);
`endif

    $display("[TB] reset mid-stream");
    rst         = 1'b1;
    bus.link_in = '0;
    #1;
    check_all_zero("midrst");
    step();
    rst      = 1'b0;
    snap_upd = upd_cnt;
    repeat (20) step();
    checkOutput("midrst_no_update", upd_cnt - snap_upd, 0);
    checkOutput("midrst_link_down", bus.link_up, 1'b0);

    applyStimulus(4'h3, 3'b101);
    wait_link_up("link_up_after_midrst");
    repeat (10) step();
    checkOutput("relink_flags", bus.rx_flags, 3'b101);
    checkOutput("relink_data", bus.rx_data, 4'h3);

    $display("[TB] heartbeat timeout");
    wait_hb_edge("timeout_hb_sync");
    loop_en = 1'b0;
    n = 0;
    while (cyc < last_hb_cyc + TIMEOUT + 2 && n < TIMEOUT + 10) begin
      step();
      n++;
    end
    checkOutput("timeout_still_up", bus.link_up, 1'b1);
    checkOutput("timeout_flags_before", bus.rx_flags, 3'b101);
    step();
    checkOutput("timeout_link_down", bus.link_up, 1'b0);
    checkOutput("timeout_flags_cleared", bus.rx_flags, 3'b000);
    checkOutput("timeout_no_rise", bus.rx_flag_rise, 3'b000);
    checkOutput("timeout_no_update", bus.rx_update, 1'b0);
    checkOutput("timeout_data_holds", bus.rx_data, 4'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
